// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and the fixed bus addresses it uses.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } oam_dma_state_t;

  localparam logic [15:0] NES_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] NES_OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to DMA_REG_ADDR stalls the CPU and copies page {page,00..FF} to OAM_DATA_ADDR.
// Optional macro OAM_DMA_ALIGN_EN inserts one ALIGN cycle when the HALT cycle has odd parity.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic        cpu_ready,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  output logic        dma_active
);

  oam_dma_state_t r_state, w_next;
  logic [7:0] r_page, r_cnt, r_buf;
  logic       r_parity;
  logic       w_trigger, w_align;

`ifdef OAM_DMA_ALIGN_EN
  assign w_align = r_parity;
`else
  logic w_unused_parity;
  assign w_align         = 1'b0;
  assign w_unused_parity = r_parity;
`endif

  assign w_trigger  = (r_state == ST_IDLE) && cpu_write && (cpu_addr == DMA_REG_ADDR);
  assign dma_active = (r_state != ST_IDLE);

  always_comb begin
    w_next    = r_state;
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_write = 1'b0;
    cpu_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // reset forces IDLE asynchronously, so gating here keeps the bus quiet during reset
        bus_write = cpu_write & ~reset;
        cpu_ready = 1'b1;
        if (w_trigger) w_next = ST_HALT;
      end
      ST_HALT:  w_next = w_align ? ST_ALIGN : ST_READ;
      ST_ALIGN: w_next = ST_READ;
      ST_READ: begin
        bus_addr = {r_page, r_cnt};
        w_next   = ST_WRITE;
      end
      ST_WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = r_buf;
        bus_write = 1'b1;
        w_next    = (r_cnt == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_page   <= 8'h00;
      r_cnt    <= 8'h00;
      r_buf    <= 8'h00;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_parity <= ~r_parity;
      if (w_trigger) begin
        r_page <= cpu_d_out;
        r_cnt  <= 8'h00;
      end
      if (r_state == ST_READ)  r_buf <= bus_d_in;
      if (r_state == ST_WRITE) r_cnt <= r_cnt + 8'h01;
    end
  end

endmodule
